// File: rtl/sig_pkg.sv
// Shared light codes, request FSM encoding and default timing for the country-road request path.
// Latency: n/a (types and constants only); no backpressure.
package sig_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVE   = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam int DEBOUNCE_DEF  = 4;
    localparam int GAP_DEF       = 3;
    localparam int MAX_GREEN_DEF = 20;

endpackage

// File: rtl/cntry_debounce.sv
// Two-flop synchroniser plus debounce filter for the country loop detector.
// Latency: car_present follows car_raw after 2+DEBOUNCE edges; no backpressure (free-running).
module cntry_debounce
    import sig_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int CNT_W    = 5
) (
    input  logic clock,
    input  logic clear_n,
    input  logic car_raw,
    output logic car_present
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q, car_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             present_q, present_d;

    always_comb begin
        cnt_d     = '0;
        present_d = present_q;
        // The toggle and the counter clear share the edge where the count completes.
        if (car_s_q != present_q) begin
            if (cnt_q == CNT_LAST) begin
                present_d = ~present_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync1_q   <= 1'b0;
            car_s_q   <= 1'b0;
            cnt_q     <= '0;
            present_q <= 1'b0;
        end else begin
            sync1_q   <= car_raw;
            car_s_q   <= sync1_q;
            cnt_q     <= cnt_d;
            present_q <= present_d;
        end
    end

    assign car_present = present_q;

endmodule

// File: rtl/cntry_request.sv
// Country-road car-waiting request X with gap-out/max-out release; optional CNTRY_HWY_MIN_GREEN_EN holds X low HWY_MIN cycles after service.
// Latency: X rises 3+DEBOUNCE edges after car_raw is first sampled high; no backpressure (controller light is observed, never stalled).
module cntry_request
    import sig_pkg::*;
#(
    parameter int DEBOUNCE  = DEBOUNCE_DEF,
    parameter int GAP       = GAP_DEF,
    parameter int MAX_GREEN = MAX_GREEN_DEF,
    parameter int CNT_W     = 5,
    parameter int HWY_MIN   = 8
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       car_raw,
    input  logic [1:0] cntry,
    output logic       X,
    output logic       car_present,
    output logic       maxout
);

    if (DEBOUNCE < 1 || GAP < 1 || MAX_GREEN < 2 || (2 ** CNT_W) <= DEBOUNCE ||
        (2 ** CNT_W) <= GAP || (2 ** CNT_W) <= MAX_GREEN || (2 ** CNT_W) <= HWY_MIN) begin : g_bad_cfg
        $error("cntry_request: parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(MAX_GREEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] grn_q, grn_d;
    logic             maxout_q, maxout_d;
`ifdef CNTRY_HWY_MIN_GREEN_EN
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HWY_MIN);
    logic [CNT_W-1:0] hold_q, hold_d;
`endif

    cntry_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CNT_W    (CNT_W)
    ) u_debounce (
        .clock       (clock),
        .clear_n     (clear_n),
        .car_raw     (car_raw),
        .car_present (car_present)
    );

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        grn_d    = grn_q;
        maxout_d = 1'b0;
`ifdef CNTRY_HWY_MIN_GREEN_EN
        hold_d   = hold_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef CNTRY_HWY_MIN_GREEN_EN
                if (hold_q != '0) begin
                    hold_d = hold_q - CNT_W'(1);
                end
                if (car_present && hold_q == '0) begin
                    state_d = REQUEST;
                end
`else
                if (car_present) begin
                    state_d = REQUEST;
                end
`endif
            end
            REQUEST: begin
                // Latched: only the controller going green moves us on, not the car leaving.
                if (cntry == GREEN) begin
                    state_d = SERVE;
                    gap_d   = '0;
                    grn_d   = '0;
                end
            end
            SERVE: begin
                if (grn_q != GRN_LAST) begin
                    grn_d = grn_q + CNT_W'(1);
                end
                if (car_present) begin
                    gap_d = '0;
                end else if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + CNT_W'(1);
                end
                if (grn_q == GRN_LAST) begin
                    state_d  = RELEASE;
                    maxout_d = 1'b1;
                end else if (!car_present && gap_q == GAP_LAST) begin
                    state_d = RELEASE;
                end else if (cntry != GREEN) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (cntry == RED) begin
                    state_d = IDLE;
`ifdef CNTRY_HWY_MIN_GREEN_EN
                    hold_d  = HOLD_LOAD;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            grn_q    <= '0;
            maxout_q <= 1'b0;
`ifdef CNTRY_HWY_MIN_GREEN_EN
            hold_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            grn_q    <= grn_d;
            maxout_q <= maxout_d;
`ifdef CNTRY_HWY_MIN_GREEN_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign X      = (state_q == REQUEST) || (state_q == SERVE);
    assign maxout = maxout_q;

endmodule

// File: doc/cntry_request.md
Name: cntry_request

Overview:
- Upstream stage of the highway/country signal controller; produces its car-waiting input X.
- Conditions the raw country-road loop-detector signal: synchronises it, debounces it, and latches a service request.
- Watches the controller's country light to decide when to drop X:
  - gap-out: no car for GAP cycles while country is GREEN;
  - max-out: country has been GREEN for MAX_GREEN cycles.

Parameters:
DEBOUNCE, 4, consecutive synchronised samples required to change car_present (>=1)
GAP, 3, consecutive car-absent cycles during country green that end service (>=1)
MAX_GREEN, 20, maximum cycles X is held during country green (>=2)
CNT_W, 5, width of all internal counters; must hold max(DEBOUNCE, GAP, MAX_GREEN, HWY_MIN)
HWY_MIN, 8, highway minimum-green cycles; used only with optional feature

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
car_raw  in  1  raw loop detector, asynchronous to clock
cntry  in  2  country light from controller: RED=0, YELLOW=1, GREEN=2
X  out  1  car-waiting request to controller
car_present  out  1  debounced detector state
maxout  out  1  one-cycle pulse when service ends by max-out

Behaviour:
- Reset (clear_n low, asynchronous): synchronisers, counters, car_present, maxout = 0; FSM = IDLE; X = 0. Takes effect immediately, including mid-service; release is synchronous to the next clock edge.
- Synchroniser: two flops, car_s = second stage.
- Debounce:
  - counter increments while car_s != car_present, clears when equal;
  - car_present toggles on the edge where the count reaches DEBOUNCE, and the counter clears at that edge;
  - latency: car_raw high before edge 1 -> car_present high after edge 2+DEBOUNCE. A glitch shorter than DEBOUNCE cycles has no effect.
- FSM (registered):
  - IDLE: X=0. car_present=1 -> REQUEST.
  - REQUEST: X=1. Request is latched: a car leaving does not clear it. cntry==GREEN -> SERVE; clear gap_cnt and grn_cnt.
  - SERVE: X=1.
    - grn_cnt increments every cycle.
    - gap_cnt increments when car_present=0 and clears when car_present=1.
    - Max-out: grn_cnt==MAX_GREEN-1 -> RELEASE, maxout=1 for that cycle.
    - Otherwise gap-out: gap_cnt==GAP-1 and car_present=0 -> RELEASE.
    - Otherwise cntry != GREEN (controller left early) -> RELEASE, no maxout.
    - Max-out takes priority when it coincides with gap-out.
  - RELEASE: X=0. cntry==RED -> IDLE.
- X is decoded from the registered state only (glitch-free): X rises on edge 3+DEBOUNCE after car_raw first sampled high.
- Counters never wrap; they saturate at their terminal value.
- maxout is registered alongside the state transition; it is never asserted two cycles in a row.
- Car still present at RELEASE -> IDLE: re-request the following cycle (without the optional feature).

Optional Feature:
- Macro: CNTRY_HWY_MIN_GREEN_EN.
- Defined:
  - on RELEASE -> IDLE, load hold_cnt = HWY_MIN;
  - hold_cnt decrements each cycle in IDLE;
  - IDLE -> REQUEST only when car_present=1 and hold_cnt==0;
  - guarantees the highway HWY_MIN cycles of X=0 after any service;
  - reset clears hold_cnt to 0.
- Undefined: hold_cnt, the HWY_MIN logic and the stall do not exist; IDLE -> REQUEST on car_present alone.

Decomposition:
- Shared package sig_pkg:
  - light codes RED/YELLOW/GREEN (2-bit);
  - FSM state encoding IDLE/REQUEST/SERVE/RELEASE (2-bit);
  - DEBOUNCE/GAP/MAX_GREEN defaults.
- One sub-module, cntry_debounce:
  - contents: two-flop synchroniser + debounce counter;
  - parameters: DEBOUNCE, CNT_W;
  - ports: clock, clear_n, car_raw -> car_present.
- The FSM, gap/green counters and the optional hold live in cntry_request.

Test Plan:
- Debounce: car_raw high for 3 cycles, then low (DEBOUNCE=4) -> car_present and X stay 0. car_raw held high -> car_present=1 after edge 6, X=1 after edge 7.
- Latched request: car present 10 cycles, removed, cntry held RED -> X stays 1. cntry=GREEN -> SERVE. Car absent -> X falls 3 cycles later (gap-out), maxout=0.
- Max-out: car held present, cntry=GREEN -> X falls on cycle 20 of green with a one-cycle maxout pulse. Set cntry=YELLOW then RED -> X re-asserts the next cycle (macro off).
- Early leave: in SERVE, cntry goes YELLOW at green cycle 5 -> RELEASE, X=0, maxout=0. Return to IDLE only after cntry=RED.
- Reset mid-service: assert clear_n low in SERVE asynchronously -> X=0, car_present=0, maxout=0 immediately. After release with car present -> X=1 after edge 7 again.
- CNTRY_HWY_MIN_GREEN_EN, HWY_MIN=8: car continuously present after max-out and cntry=RED -> X stays 0 for 8 cycles in IDLE, then re-asserts.
